// File: rtl/gf_pkg.sv
// GF(2^8) field definition and state types shared by the RS datapath blocks.
// Latency: n/a (types, constants and a combinational field multiply).
// Backpressure: n/a.
package gf_pkg;

    localparam int SYMB_WIDTH = 8;
    // Primitive polynomial x^8 + x^4 + x^3 + x^2 + 1, the usual Reed-Solomon field.
    localparam logic [SYMB_WIDTH:0] GF_PRIM_POLY = 9'h11D;

    typedef enum logic [1:0] {
        GF_ST_IDLE = 2'd0,
        GF_ST_LOAD = 2'd1,
        GF_ST_DONE = 2'd2
    } gf_eval_state_t;

    // Shift-and-add multiply, reducing by the primitive polynomial on every shift.
    function automatic logic [SYMB_WIDTH-1:0] gf_mul(input logic [SYMB_WIDTH-1:0] a,
                                                     input logic [SYMB_WIDTH-1:0] b);
        logic [SYMB_WIDTH-1:0] r;
        logic [SYMB_WIDTH-1:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) r = r ^ t;
            t = t[SYMB_WIDTH-1] ? ((t << 1) ^ GF_PRIM_POLY[SYMB_WIDTH-1:0]) : (t << 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_mult.sv
// Combinational GF(2^SYMB_WIDTH) multiplier.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
module gf_mult
    import gf_pkg::*;
(
    input  logic [SYMB_WIDTH-1:0] a,
    input  logic [SYMB_WIDTH-1:0] b,
    output logic [SYMB_WIDTH-1:0] p
);

    assign p = gf_mul(a, b);

endmodule

// File: rtl/gf_poly_eval.sv
// Horner evaluation of P(X) over GF(2^8), one coefficient per clock, highest degree first.
// Latency: res_valid one clock after the last coefficient (or after start when N=0).
// Backpressure: result held until res_ready; coef_ready drops once N coefficients are taken.
module gf_poly_eval
    import gf_pkg::*;
#(
    parameter int COEF_NUM_MAX = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_valid,
    output logic                                  start_ready,
    input  logic [SYMB_WIDTH-1:0]                 start_x,
    input  logic [$clog2(COEF_NUM_MAX+1)-1:0]     start_len,
    input  logic                                  coef_valid,
    output logic                                  coef_ready,
    input  logic [SYMB_WIDTH-1:0]                 coef_data,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [SYMB_WIDTH-1:0]                 res_data
);

    localparam int LEN_W = $clog2(COEF_NUM_MAX + 1);

    gf_eval_state_t        state_q, state_d;
    logic [SYMB_WIDTH-1:0] x_q;
    logic [SYMB_WIDTH-1:0] acc_q;
    logic [SYMB_WIDTH-1:0] prod;
    logic [LEN_W-1:0]      n_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [LEN_W-1:0]      len_clamp;
    logic                  start_hs;
    logic                  coef_hs;
    logic                  res_hs;
    logic                  last_coef;

    // Every output comes straight from the state register or acc.
    assign start_ready = (state_q == GF_ST_IDLE);
    assign coef_ready  = (state_q == GF_ST_LOAD);
    assign res_valid   = (state_q == GF_ST_DONE);
    assign res_data    = acc_q;

    assign start_hs  = start_valid & start_ready;
    assign coef_hs   = coef_valid & coef_ready;
    assign res_hs    = res_valid & res_ready;
    assign len_clamp = (start_len > LEN_W'(COEF_NUM_MAX)) ? LEN_W'(COEF_NUM_MAX) : start_len;
    assign last_coef = ((cnt_q + LEN_W'(1)) == n_q);

    gf_mult u_gf_mult (
        .a (acc_q),
        .b (x_q),
        .p (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GF_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GF_ST_IDLE: if (start_hs) state_d = (len_clamp == '0) ? GF_ST_DONE : GF_ST_LOAD;
            GF_ST_LOAD: if (coef_hs && last_coef) state_d = GF_ST_DONE;
            GF_ST_DONE: if (res_hs) state_d = GF_ST_IDLE;
            default:    state_d = GF_ST_IDLE;
        endcase
    end

    // cnt_q only advances in LOAD while below n_q, and n_q is clamped, so it cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            n_q   <= '0;
            cnt_q <= '0;
            acc_q <= '0;
        end else if (start_hs) begin
            x_q   <= start_x;
            n_q   <= len_clamp;
            cnt_q <= '0;
            acc_q <= '0;
        end else if (coef_hs) begin
            acc_q <= prod ^ coef_data;
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_gf_poly_eval.sv
// Scoreboard bench for gf_poly_eval: stimulus pushes reference results, a monitor pops on each result handshake.
module tb_gf_poly_eval;
    import gf_pkg::*;

    localparam int CMAX = 16;
    localparam int LW   = $clog2(CMAX + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [7:0]     start_x = '0;
    logic [LW-1:0]  start_len = '0;
    logic           coef_valid = 1'b0;
    logic           coef_ready;
    logic [7:0]     coef_data = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [7:0]     res_data;

    int             total = 0;
    int             bad = 0;
    bit [7:0]       exp_q[$];
    bit [7:0]       cq[$];
    bit             rdy_rand = 1'b0;

    gf_poly_eval #(.COEF_NUM_MAX(CMAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_x     (start_x),
        .start_len   (start_len),
        .coef_valid  (coef_valid),
        .coef_ready  (coef_ready),
        .coef_data   (coef_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
    );

    always #5 clk = ~clk;

    // Reference field arithmetic: carry-less product then long-division reduction.
    function automatic bit [7:0] ref_mul(input bit [7:0] a, input bit [7:0] b);
        bit [15:0] p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
        return p[7:0];
    endfunction

    function automatic bit [7:0] ref_pow(input bit [7:0] x, input int e);
        bit [7:0] r = 8'h01;
        for (int i = 0; i < e; i++) r = ref_mul(r, x);
        return r;
    endfunction

    // P(X) = sum of c[k] * X^(n-1-k), written as an explicit power sum.
    function automatic bit [7:0] ref_eval(input bit [7:0] x, input int n);
        bit [7:0] s = '0;
        for (int k = 0; k < n; k++) s = s ^ ref_mul(cq[k], ref_pow(x, n - 1 - k));
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                timeout("res_unexpected");
            end else begin
                check("res_data", res_data, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rdy_rand) res_ready = 1'($urandom_range(0, 1));
    end

    task automatic do_start(input bit [7:0] x, input int len);
        int g = 0;
        start_valid = 1'b1;
        start_x     = x;
        start_len   = LW'(len);
        while (!start_ready && g < 300) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 300) timeout("start_handshake");
        @(posedge clk); #1;
        start_valid = 1'b0;
        start_x     = 8'($urandom);
        start_len   = LW'($urandom);
    endtask

    task automatic eval(input bit [7:0] x, input int len, input int smin, input int smax);
        int n = (len > CMAX) ? CMAX : len;
        int g;
        exp_q.push_back(ref_eval(x, n));
        do_start(x, len);
        if (n == 0) check("latency_n0", res_valid, 1);
        for (int k = 0; k < n; k++) begin
            int st = $urandom_range(smin, smax);
            for (int s = 0; s < st; s++) begin
                coef_valid = 1'b0;
                coef_data  = 8'($urandom);
                check("stall_hold", {coef_ready, res_valid}, 2'b10);
                @(posedge clk); #1;
            end
            coef_valid = 1'b1;
            coef_data  = cq[k];
            g = 0;
            while (!coef_ready && g < 300) begin
                @(posedge clk); #1; g++;
            end
            if (g >= 300) timeout("coef_handshake");
            @(posedge clk); #1;
        end
        coef_valid = 1'b0;
        coef_data  = 8'($urandom);
        if (n > 0) check("latency", res_valid, 1);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 300) timeout("drain");
    endtask

    initial begin
        int consumed;
        // Reset state.
        #12;
        check("rst_start_ready", start_ready, 1);
        check("rst_coef_ready", coef_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;

        // X=2, {1,0} -> 2; start on first clock after reset.
        cq = {8'h01, 8'h00};
        eval(8'h02, 2, 0, 0);
        drain();

        // Stalls of 3 cycles between coefficients.
        cq = {8'h01, 8'h01, 8'h01};
        eval(8'h02, 3, 3, 3);
        drain();

        // X=1 gives XOR of all, X=0 gives the constant term.
        cq = {8'h12, 8'h34, 8'h56, 8'h78};
        eval(8'h01, 4, 0, 1);
        drain();
        eval(8'h00, 4, 0, 1);
        drain();

        // N=0 with result held back for 5 cycles.
        res_ready = 1'b0;
        eval(8'h5A, 0, 0, 0);
        check("n0_data", res_data, 0);
        start_valid = 1'b1;
        start_len   = LW'(2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, 0);
            check("hold_start_ready", start_ready, 0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        drain();
        @(posedge clk); #1;

        // Abort mid-load with reset, then a clean request.
        do_start(8'h37, 4);
        coef_valid = 1'b1;
        coef_data  = 8'hA5;
        @(posedge clk); #1;
        coef_data  = 8'h3C;
        @(posedge clk); #1;
        coef_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check("abort_res_valid", res_valid, 0);
        check("abort_start_ready", start_ready, 1);
        check("abort_coef_ready", coef_ready, 0);
        check("abort_res_data", res_data, 0);
        @(posedge clk); #1;
        cq = {8'h01, 8'h00};
        eval(8'h02, 2, 0, 0);
        drain();

        // Over-length request clamps to CMAX with coef_valid held high.
        cq.delete();
        for (int i = 0; i < CMAX + 3; i++) cq.push_back(8'($urandom));
        res_ready = 1'b0;
        exp_q.push_back(ref_eval(8'h01, CMAX));
        do_start(8'h01, CMAX + 3);
        consumed = 0;
        coef_valid = 1'b1;
        for (int i = 0; i < CMAX + 6; i++) begin
            coef_data = cq[(consumed < CMAX + 3) ? consumed : 0];
            if (coef_ready) consumed++;
            @(posedge clk); #1;
        end
        coef_valid = 1'b0;
        check("clamp_consumed", consumed, CMAX);
        check("clamp_coef_ready", coef_ready, 0);
        res_ready = 1'b1;
        drain();

        // Randomised back-to-back traffic with random result backpressure.
        rdy_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int len = $urandom_range(0, CMAX + 3);
            cq.delete();
            for (int i = 0; i < CMAX + 3; i++) cq.push_back(8'($urandom));
            eval(8'($urandom), len, 0, 2);
        end
        drain();
        rdy_rand = 1'b0;
        @(posedge clk); #3;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf_poly_eval.md
GF_POLY_EVAL -- requirements
Module: gf_poly_eval

Interface
REQ-001 SHALL have parameter COEF_NUM_MAX, default 16: maximum number of coefficients per evaluation.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start_valid  input  1  an evaluation request is present.
REQ-005 SHALL have port start_ready  output  1  the block accepts a request.
REQ-006 SHALL have port start_x  input  SYMB_WIDTH  the evaluation point X.
REQ-007 SHALL have port start_len  input  $clog2(COEF_NUM_MAX+1)  the coefficient count N, from 0 to COEF_NUM_MAX.
REQ-008 SHALL have port coef_valid  input  1  a coefficient is present.
REQ-009 SHALL have port coef_ready  output  1  the block accepts a coefficient.
REQ-010 SHALL have port coef_data  input  SYMB_WIDTH  the coefficient; the highest degree arrives first.
REQ-011 SHALL have port res_valid  output  1  a result is available.
REQ-012 SHALL have port res_ready  input  1  the consumer accepts the result.
REQ-013 SHALL have port res_data  output  SYMB_WIDTH  the polynomial value P(X).

Function
REQ-014 SHALL implement the FSM IDLE -> LOAD -> DONE -> IDLE.
REQ-015 IDLE: start_ready=1, coef_ready=0, res_valid=0.
- On start_valid, register X and N, clear acc and the count.
- Go to LOAD if N>0; go to DONE if N=0.
REQ-016 LOAD: coef_ready=1, start_ready=0.
- Each accepted coefficient (coef_valid&coef_ready) updates acc <= gf_mult(acc, X) XOR coef_data in the same cycle and increments the count.
- Throughput is one coefficient per clock.
REQ-017 LOAD: when the N-th coefficient is accepted, the next state SHALL be DONE.
- coef_ready SHALL be 0 from the next cycle on, so extra coefficients are never consumed.
REQ-018 LOAD: cycles without coef_valid SHALL hold acc and the count unchanged; stalls of any length are allowed.
REQ-019 DONE: res_valid=1 and res_data=acc, both held stable until res_ready.
- On res_valid&res_ready, go to IDLE.
- start_ready SHALL be 0 in DONE, so a new start is only accepted on the cycle after the result handshake.
REQ-020 Latency: res_valid SHALL rise on the clock after the last coefficient handshake, or after the start handshake when N=0.
REQ-021 N=0 SHALL give res_data=0.
REQ-022 Arithmetic SHALL be GF(2^SYMB_WIDTH): addition is bitwise XOR and multiplication uses gf_mult, so multiplication by 0 gives 0.
REQ-023 start_len>COEF_NUM_MAX is illegal.
- The block SHALL clamp N to COEF_NUM_MAX.
- The count SHALL never wrap.
REQ-024 start_x, start_len and coef_data SHALL be ignored outside their handshake cycles.
REQ-025 X SHALL be registered, so changes on start_x during LOAD do not affect the result.

Reset
REQ-026 Asserting rst at any time, including mid-LOAD or in DONE, SHALL immediately force IDLE.
- acc, X, N and the count go to 0.
- res_valid=0, coef_ready=0, res_data=0.
REQ-027 start_ready SHALL be 1 while in IDLE after reset.
- A partially loaded evaluation is discarded without a result.
REQ-028 A start handshake SHALL be possible on the first clock after rst deasserts.

Structure
REQ-029 SYMB_WIDTH and the GF field tables SHALL come from gf_pkg.
- The FSM state enum SHALL be a typedef in gf_pkg, shared by later RS controllers.
REQ-030 The block SHALL instantiate exactly one gf_mult as a sub-module, with inputs acc and the registered X.
- It SHALL contain no other multiplier.
REQ-031 All outputs SHALL be driven directly from state registers or from acc, with no combinational path from inputs to outputs.

Verification
REQ-032 X=0x02, N=2, coefs {0x01,0x00} -> res_data=0x02, res_valid on the cycle after the 2nd coefficient.
REQ-033 X=0x02, N=3, coefs {0x01,0x01,0x01} with coef_valid stalled 3 cycles between coefficients -> res_data=0x07; acc holds during the stalls.
REQ-034 X=0x01, N=4, coefs {0x12,0x34,0x56,0x78} -> res_data=0x08 (XOR of all); X=0x00 with the same coefs -> res_data=0x78.
REQ-035 N=0 -> res_valid on the next cycle with res_data=0x00; then res_ready held low 5 cycles -> res_valid and res_data stable and start_ready=0.
REQ-036 rst pulsed after 2 of 4 coefficients -> next cycle in IDLE with res_valid=0; a fresh request X=0x02, N=2, coefs {0x01,0x00} -> 0x02, with no residue from the aborted run.
REQ-037 start_len=COEF_NUM_MAX+3 with X=0x01 and coef_valid held high -> exactly COEF_NUM_MAX coefficients consumed, then coef_ready=0.
